// File: rtl/request_encoder.sv
// Sequential 32-to-5 encoder: loads a multi-hot request mask and emits one index
// per handshake, lowest set bit first, until the mask is drained or flushed.
module request_encoder #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_mask,
    output logic             load_ready,
    input  logic             flush,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx,
    output logic             last,
    output logic [IDX_W:0]   remaining,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for a load; load_ready high, no index offered
    // DRAIN | offering lowest pending index each cycle until the mask is empty
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] pending, pending_next;
    logic [IDX_W:0]   remaining_q, remaining_next;
    logic [IDX_W:0]   load_count;
    logic [IDX_W-1:0] idx_low;
    logic             last_int;

    always_comb begin
        load_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_count = load_count + {{IDX_W{1'b0}}, load_mask[i]};
        end
    end

    // Scanning from the top down leaves the lowest set bit as the final winner.
    always_comb begin
        idx_low = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx_low = IDX_W'(i);
            end
        end
    end

    assign last_int = (state == DRAIN) && (remaining_q == (IDX_W + 1)'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pending     <= '0;
            remaining_q <= '0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            remaining_q <= remaining_next;
        end
    end

    always_comb begin
        state_next     = state;
        pending_next   = pending;
        remaining_next = remaining_q;
        if (flush) begin
            state_next     = IDLE;
            pending_next   = '0;
            remaining_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid && (load_mask != '0)) begin
                        state_next     = DRAIN;
                        pending_next   = load_mask;
                        remaining_next = load_count;
                    end
                end
                DRAIN: begin
                    if (idx_ready) begin
                        pending_next   = pending & ~(WIDTH'(1) << idx_low);
                        remaining_next = remaining_q - (IDX_W + 1)'(1);
                        if (last_int) begin
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign load_ready = (state == IDLE);
    assign idx_valid  = (state == DRAIN);
    assign busy       = (state == DRAIN);
    assign idx        = idx_low;
    assign last       = last_int;
    assign remaining  = remaining_q;

endmodule

// File: tb/tb_request_encoder.sv
// Bench for request_encoder: table of masks drained against a scoreboard of
// expected (idx, last, remaining) triples, plus flush and async-reset sequences.
module tb_request_encoder;

    logic        clock;
    logic        reset_n;
    logic        load_valid;
    logic [31:0] load_mask;
    logic        load_ready;
    logic        flush;
    logic        idx_valid;
    logic        idx_ready;
    logic [4:0]  idx;
    logic        last;
    logic [5:0]  remaining;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] mask;
        bit          toggle;
        bit          junk_load;
        int          exp_transfers;
        int          exp_first_rem;
    } vec_t;

    typedef struct {
        logic [4:0] idx;
        logic       last;
        logic [5:0] rem;
    } exp_t;

    vec_t vecs[6];

    request_encoder #(.WIDTH(32), .IDX_W(5)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_mask  (load_mask),
        .load_ready (load_ready),
        .flush      (flush),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .idx        (idx),
        .last       (last),
        .remaining  (remaining),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t       q[$];
        int         rem;
        int         transfers;
        bit         phase;
        bit         done;
        bit         first_seen;
        logic [5:0] first_rem;
        exp_t       e;

        rem = 0;
        for (int i = 0; i < 32; i++) if (v.mask[i]) rem++;
        for (int i = 0; i < 32; i++) begin
            if (v.mask[i]) begin
                e.idx  = 5'(i);
                e.last = (rem == 1);
                e.rem  = 6'(rem);
                q.push_back(e);
                rem--;
            end
        end

        check("load_ready_before_load", load_ready, 1);
        load_valid = 1'b1;
        load_mask  = v.mask;
        @(posedge clock); #1;
        load_valid = 1'b0;
        load_mask  = $urandom;

        transfers  = 0;
        phase      = 1'b1;
        done       = 1'b0;
        first_seen = 1'b0;
        first_rem  = '0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            idx_ready = v.toggle ? phase : 1'b1;
            if (v.junk_load) begin
                load_valid = 1'b1;
                load_mask  = 32'hFFFF_0000;
            end
            @(negedge clock);
            if (idx_valid) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_rem  = remaining;
                end
                if (q.size() == 0) begin
                    check("unexpected_idx_valid", idx_valid, 0);
                    done = 1'b1;
                end else begin
                    check("idx", idx, q[0].idx);
                    check("last", last, q[0].last);
                    check("remaining", remaining, q[0].rem);
                    check("busy_drain", busy, 1);
                    check("load_ready_drain", load_ready, 0);
                    if (idx_ready) begin
                        void'(q.pop_front());
                        transfers++;
                    end
                end
            end else begin
                check("idle_remaining", remaining, 0);
                check("idle_load_ready", load_ready, 1);
                check("idle_last", last, 0);
                done = 1'b1;
            end
            if (done) load_valid = 1'b0;
            phase = ~phase;
            @(posedge clock); #1;
        end
        load_valid = 1'b0;
        idx_ready  = 1'b0;
        check("drain_finished_in_budget", done, 1);
        check("transfers", transfers, v.exp_transfers);
        check("scoreboard_empty", q.size(), 0);
        check("first_remaining", first_rem, v.exp_first_rem);
    endtask

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_mask  = '0;
        flush      = 1'b0;
        idx_ready  = 1'b0;

        vecs[0] = '{32'h0000_0001, 1'b0, 1'b0, 1, 1};
        vecs[1] = '{32'h8000_0001, 1'b0, 1'b0, 2, 2};
        vecs[2] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 32, 32};
        vecs[3] = '{32'h0000_00A4, 1'b1, 1'b0, 3, 3};
        vecs[4] = '{32'h0000_0000, 1'b0, 1'b0, 0, 0};
        vecs[5] = '{32'h0000_0003, 1'b0, 1'b1, 2, 2};

        #12;
        check("rst_idx_valid", idx_valid, 0);
        check("rst_idx", idx, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_load_ready", load_ready, 1);
        check("rst_remaining", remaining, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        foreach (vecs[k]) run_vec(vecs[k]);

        // Flush after the idx=12 transfer; idx=13 offered alongside flush is dropped.
        load_valid = 1'b1;
        load_mask  = 32'h0000_F000;
        @(posedge clock); #1;
        load_valid = 1'b0;
        idx_ready  = 1'b1;
        @(negedge clock);
        check("flush_pre_idx", idx, 12);
        check("flush_pre_remaining", remaining, 4);
        @(posedge clock); #1;
        flush = 1'b1;
        @(negedge clock);
        check("flush_cycle_idx", idx, 13);
        check("flush_cycle_remaining", remaining, 3);
        @(posedge clock); #1;
        flush = 1'b0;
        @(negedge clock);
        check("flush_idx_valid", idx_valid, 0);
        check("flush_remaining", remaining, 0);
        check("flush_load_ready", load_ready, 1);
        check("flush_busy", busy, 0);
        repeat (3) begin
            @(negedge clock);
            check("post_flush_no_idx", idx_valid, 0);
        end

        // Flush wins over a simultaneous load.
        @(posedge clock); #1;
        flush      = 1'b1;
        load_valid = 1'b1;
        load_mask  = 32'h0000_0005;
        @(posedge clock); #1;
        flush      = 1'b0;
        load_valid = 1'b0;
        @(negedge clock);
        check("flush_vs_load_idx_valid", idx_valid, 0);
        check("flush_vs_load_remaining", remaining, 0);

        // Async reset mid-drain.
        @(posedge clock); #1;
        load_valid = 1'b1;
        load_mask  = 32'h0000_F000;
        idx_ready  = 1'b0;
        @(posedge clock); #1;
        load_valid = 1'b0;
        @(negedge clock);
        check("pre_reset_idx_valid", idx_valid, 1);
        check("pre_reset_remaining", remaining, 4);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_idx_valid", idx_valid, 0);
        check("async_rst_remaining", remaining, 0);
        check("async_rst_idx", idx, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_load_ready", load_ready, 1);
        @(posedge clock); #1;
        reset_n   = 1'b1;
        idx_ready = 1'b1;
        repeat (4) begin
            @(negedge clock);
            check("post_reset_no_idx", idx_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/request_encoder.md
Name: request_encoder

Overview:
- Sequential 32-to-5 encoder; the inverse of the 5-to-32 register-select decoder.
- Loads a 32-bit multi-hot request mask and emits one 5-bit index per handshake, lowest set bit first, until the mask is drained.
- Used to serialise multi-register requests (register-list ops, pending-write scoreboard drain) into the register-file select path.
- Invariant: driving idx through the 5-to-32 decoder yields exactly the one-hot bit cleared from the pending mask on that transfer.

Parameters:
- WIDTH, 32, request mask width; must equal 2**IDX_W.
- IDX_W, 5, index width.

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  load request; load_mask is valid.
- load_mask  input  WIDTH  multi-hot request vector.
- load_ready  output  1  block can accept a load.
- flush  input  1  synchronous abort of the current drain.
- idx_valid  output  1  idx is valid.
- idx_ready  input  1  consumer accepts idx this cycle.
- idx  output  IDX_W  index of the lowest set bit of the pending mask.
- last  output  1  idx is the final pending bit.
- remaining  output  IDX_W+1  count of pending bits, 0..32.
- busy  output  1  high in the DRAIN state.

Behaviour:
- Reset (reset_n low, async): state=IDLE, pending=0, remaining=0.
  - Outputs: idx_valid=0, idx=0, last=0, busy=0, load_ready=1.
- State IDLE:
  - load_ready=1, idx_valid=0.
  - A load is accepted when load_valid=1 at the clock edge.
  - Nonzero load_mask: pending<=load_mask, remaining<=popcount(load_mask), next state DRAIN.
  - Zero load_mask: accepted, no index is emitted, block stays in IDLE, remaining stays 0.
- State DRAIN:
  - load_ready=0 and busy=1; load_valid is ignored.
  - idx_valid=1.
  - idx = position of the lowest set bit of the pending register. It is a combinational function of registered state only; no input-to-output combinational path exists.
  - last=1 when remaining==1.
  - On handshake (idx_valid&idx_ready at the edge): clear pending[idx] and decrement remaining by 1.
  - If last=1 on that handshake: next state IDLE; pending and remaining both reach 0.
  - If idx_ready=0: idx, last, remaining and pending hold stable; idx_valid stays 1, with no retraction.
- Throughput:
  - One index per cycle under continuous idx_ready.
  - First idx_valid appears the cycle after the load edge (latency 1).
  - A new load is accepted no earlier than the cycle after the last handshake, since load_ready rises in IDLE.
  - An N-bit mask occupies N DRAIN cycles plus 1 IDLE cycle minimum.
- Flush:
  - Takes effect in any state at the clock edge: pending<=0, remaining<=0, state<=IDLE.
  - Flush has priority over a simultaneous handshake or load; the index offered in that cycle is considered not transferred.
- Bounds:
  - remaining never underflows; it is 32 for an all-ones mask, hence IDX_W+1 bits.
  - Bit 31 maps to idx=31; bit 0 maps to idx=0.
- Async reset asserted mid-drain returns all state to reset values immediately; no index is emitted after reset deasserts until a new load.

Test Plan:
- Load 0x0000_0001, idx_ready=1 -> idx_valid for exactly 1 cycle with idx=0, last=1, remaining=1; then IDLE, load_ready=1.
- Load 0x8000_0001 -> idx=0 (remaining 2, last 0), then idx=31 (remaining 1, last 1); decoder(idx) matches each cleared bit.
- Load 0xFFFF_FFFF, idx_ready=1 -> remaining=32 at first valid; idx 0..31 on 32 consecutive cycles, last only on idx=31.
- Load 0x0000_00A4, idx_ready toggled 1/0 each cycle -> idx sequence 2, 5, 7 with values held stable during stalls; 3 transfers total.
- Load 0x0000_0000 -> idx_valid never asserts, load_ready stays 1, remaining=0; a load_valid during DRAIN of 0x3 is ignored and only idx 0,1 are emitted.
- Mid-drain of 0x0000_F000: assert flush after the idx=12 transfer -> IDLE next cycle, remaining=0. Repeat with reset_n pulsed low mid-drain -> outputs go to reset values asynchronously and no idx is emitted afterwards.
